// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite constants, response codes and FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

   // AXI-Lite data bus width
   localparam int AXI_DW = 32;

   // Response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Read channel FSM states
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_LAT  = 2'd1,
      R_RESP = 2'd2
   } rd_state_e;

   // Write channel FSM states
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_e;

   // Byte offset of an address relative to the window base (wraps mod 2^32)
   function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/mem_1w1r.sv
// DEPTH x 32 storage, one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from the array.
// Backpressure: none; synchronous clear has priority over a write on the same edge.
module mem_1w1r
   import axi_lite_pkg::*;
#(
   parameter int DEPTH = 32
)(
   input  logic                     clk,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [AXI_DW-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [AXI_DW-1:0]        rdata_o
);

   logic [AXI_DW-1:0] mem_q [DEPTH];

   // Clear all words or perform a single-word write
   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Reading the array before the edge gives the pre-write value on a collision
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite slave exposing a DEPTH-word memory window at BASE_ADDR; independent read/write FSMs.
// Latency: RVALID RD_LAT+1 cycles after the AR handshake; BVALID one cycle after the last of AW/W.
// Backpressure: one outstanding read and one write; ARREADY/AWREADY/WREADY drop until R/B handshake.
module axi_lite_mem_slave
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 32,
   parameter int          RD_LAT    = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [31:0]       ARADDR,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [AXI_DW-1:0] RDATA,
   output logic [1:0]        RRESP,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       AWADDR,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic [AXI_DW-1:0] WDATA,
   output logic              BVALID,
   input  logic              BREADY,
   output logic [1:0]        BRESP
);

   localparam int          IW       = $clog2(DEPTH);
   localparam logic [31:0] WIN_SIZE = 32'(DEPTH * 4);
   localparam logic [3:0]  LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   rd_state_e         rd_state_q, rd_state_d;
   logic [31:0]       rd_addr_q;
   logic [3:0]        lat_cnt_q;
   logic [AXI_DW-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              ar_hs, r_hs, rd_sample;
   logic [31:0]       rd_addr_cur, rd_off;
   logic              rd_in_range;
   logic [AXI_DW-1:0] mem_rdata;

   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   // With RD_LAT=0 the sample happens on the AR edge, before the address is latched
   assign rd_addr_cur = (rd_state_q == R_IDLE) ? ARADDR : rd_addr_q;
   assign rd_off      = addr_offset(rd_addr_cur, BASE_ADDR);
   assign rd_in_range = rd_off < WIN_SIZE;
   assign rd_sample   = (rd_state_d == R_RESP) && (rd_state_q != R_RESP);

   // Read state register
   always_ff @(posedge clk) begin
      if (reset) rd_state_q <= R_IDLE;
      else       rd_state_q <= rd_state_d;
   end

   // Read next-state logic
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (ar_hs) rd_state_d = (RD_LAT == 0) ? R_RESP : R_LAT;
         R_LAT:   if (lat_cnt_q == LAT_LAST) rd_state_d = R_RESP;
         R_RESP:  if (r_hs) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read channel outputs, forced low while in reset
   always_comb begin
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = '0;
      RRESP   = '0;
      if (!reset) begin
         ARREADY = (rd_state_q == R_IDLE);
         RVALID  = (rd_state_q == R_RESP);
         RDATA   = rdata_q;
         RRESP   = rresp_q;
      end
   end

   // Read address latch, latency counter and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr_q <= '0;
         lat_cnt_q <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         if (ar_hs) rd_addr_q <= ARADDR;
         if (rd_state_q == R_LAT) lat_cnt_q <= lat_cnt_q + 4'd1;
         else                     lat_cnt_q <= '0;
         if (rd_sample) begin
            rdata_q <= rd_in_range ? mem_rdata : '0;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   wr_state_e         wr_state_q, wr_state_d;
   logic [31:0]       awaddr_q;
   logic [AXI_DW-1:0] wdata_q;
   logic [1:0]        bresp_q;
   logic              aw_hs, w_hs, b_hs, wr_commit;
   logic [31:0]       wr_addr_cur, wr_off;
   logic [AXI_DW-1:0] wr_data_cur;
   logic              wr_in_range;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;

   // The handshake completing the pair supplies its value directly, the other comes from the latch
   assign wr_addr_cur = aw_hs ? AWADDR : awaddr_q;
   assign wr_data_cur = w_hs  ? WDATA  : wdata_q;
   assign wr_off      = addr_offset(wr_addr_cur, BASE_ADDR);
   assign wr_in_range = wr_off < WIN_SIZE;
   assign wr_commit   = (wr_state_d == W_RESP) && (wr_state_q != W_RESP);

   // Write state register
   always_ff @(posedge clk) begin
      if (reset) wr_state_q <= W_IDLE;
      else       wr_state_q <= wr_state_d;
   end

   // Write next-state logic
   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) wr_state_d = W_RESP;
            else if (aw_hs)    wr_state_d = W_DATA;
            else if (w_hs)     wr_state_d = W_ADDR;
         end
         W_ADDR:  if (aw_hs) wr_state_d = W_RESP;
         W_DATA:  if (w_hs)  wr_state_d = W_RESP;
         W_RESP:  if (b_hs)  wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Write channel outputs, forced low while in reset
   always_comb begin
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      BRESP   = '0;
      if (!reset) begin
         AWREADY = (wr_state_q == W_IDLE) || (wr_state_q == W_ADDR);
         WREADY  = (wr_state_q == W_IDLE) || (wr_state_q == W_DATA);
         BVALID  = (wr_state_q == W_RESP);
         BRESP   = bresp_q;
      end
   end

   // Write address/data latches and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         awaddr_q <= '0;
         wdata_q  <= '0;
         bresp_q  <= '0;
      end else begin
         if (aw_hs) awaddr_q <= AWADDR;
         if (w_hs)  wdata_q  <= WDATA;
         if (wr_commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   mem_1w1r #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .clr_i   (reset),
      .we_i    (wr_commit && wr_in_range),
      .waddr_i (wr_off[2 +: IW]),
      .wdata_i (wr_data_cur),
      .raddr_i (rd_off[2 +: IW]),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench: two slaves (RD_LAT=2 and RD_LAT=0) share one master stimulus.
// Latency: expectations are hand-derived cycle counts measured at the falling edge.
// Backpressure: RREADY/BREADY are driven low in directed sequences to hold responses.
module tb_axi_lite_mem_slave;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam int          DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ARVALID = 1'b0, RREADY = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
   logic [31:0] ARADDR = '0, AWADDR = '0, WDATA = '0;

   logic        ARREADY, RVALID, AWREADY, WREADY, BVALID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP, BRESP;
   logic        z_ARREADY, z_RVALID, z_AWREADY, z_WREADY, z_BVALID;
   logic [31:0] z_RDATA;
   logic [1:0]  z_RRESP, z_BRESP;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi_lite_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(2)) dut (
      .clk(clk), .reset(reset),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
   );

   axi_lite_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(0)) dut_z (
      .clk(clk), .reset(reset),
      .ARVALID(ARVALID), .ARREADY(z_ARREADY), .ARADDR(ARADDR),
      .RVALID(z_RVALID), .RREADY(RREADY), .RDATA(z_RDATA), .RRESP(z_RRESP),
      .AWVALID(AWVALID), .AWREADY(z_AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(z_WREADY), .WDATA(WDATA),
      .BVALID(z_BVALID), .BREADY(BREADY), .BRESP(z_BRESP)
   );

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;   // write data, or expected read data
      logic [1:0]  resp;   // expected response
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write with AW and W in the same cycle; lat = falling edges from handshake to BVALID
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] resp, output int lat);
      @(negedge clk);
      AWVALID = 1'b1; AWADDR = a; WVALID = 1'b1; WDATA = d; BREADY = 1'b1;
      for (int i = 0; i < 20 && !(AWREADY && WREADY); i++) @(negedge clk);
      @(negedge clk);
      AWVALID = 1'b0; WVALID = 1'b0;
      lat = 1;
      while (!BVALID && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      resp = BRESP;
      @(negedge clk);
      BREADY = 1'b0;
   endtask

   // Read with RREADY high; lat = falling edges from AR handshake to RVALID
   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
      @(negedge clk);
      ARVALID = 1'b1; ARADDR = a; RREADY = 1'b1;
      for (int i = 0; i < 20 && !ARREADY; i++) @(negedge clk);
      @(negedge clk);
      ARVALID = 1'b0;
      lat = 1;
      while (!RVALID && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      d = RDATA; resp = RRESP;
      @(negedge clk);
      RREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, held;
      logic [1:0]  r;
      int          lat, n;

      vecs[0] = '{1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{1'b0, BASE + 32'h08, 32'hDEAD_BEEF, 2'b00};
      vecs[2] = '{1'b1, BASE + 32'h7C, 32'hCAFE_0001, 2'b00};
      vecs[3] = '{1'b0, BASE + 32'h7C, 32'hCAFE_0001, 2'b00};
      vecs[4] = '{1'b1, BASE + 32'h80, 32'hFFFF_FFFF, 2'b10};
      vecs[5] = '{1'b0, BASE + 32'h00, 32'h0000_0000, 2'b00};
      vecs[6] = '{1'b0, BASE - 32'h04, 32'h0000_0000, 2'b10};
      vecs[7] = '{1'b1, BASE + 32'h0B, 32'h55AA_55AA, 2'b00};
      vecs[8] = '{1'b0, BASE + 32'h08, 32'h55AA_55AA, 2'b00};
      vecs[9] = '{1'b0, BASE + 32'h80, 32'h0000_0000, 2'b10};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst ARREADY", 32'(ARREADY), 0);
      check("rst AWREADY", 32'(AWREADY), 0);
      check("rst WREADY",  32'(WREADY),  0);
      check("rst RVALID",  32'(RVALID),  0);
      check("rst BVALID",  32'(BVALID),  0);
      reset = 1'b0;
      @(negedge clk);
      check("post-rst ARREADY", 32'(ARREADY), 1);
      check("post-rst AWREADY", 32'(AWREADY), 1);
      check("post-rst WREADY",  32'(WREADY),  1);

      // Table-driven writes and reads
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, r, lat);
            check($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].resp));
            check($sformatf("vec%0d b latency", i), 32'(lat), 1);
         end else begin
            axi_read(vecs[i].addr, d, r, lat);
            check($sformatf("vec%0d rdata", i), d, vecs[i].data);
            check($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].resp));
            check($sformatf("vec%0d r latency", i), 32'(lat), 3);
         end
      end

      // W before AW, AW three cycles later
      @(negedge clk);
      WVALID = 1'b1; WDATA = 32'h1234_5678; BREADY = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         WVALID = 1'b0;
         check($sformatf("wfirst WREADY c%0d", k), 32'(WREADY), 0);
         check($sformatf("wfirst AWREADY c%0d", k), 32'(AWREADY), 1);
         check($sformatf("wfirst BVALID c%0d", k), 32'(BVALID), 0);
      end
      AWVALID = 1'b1; AWADDR = BASE + 32'h04;
      @(negedge clk);
      AWVALID = 1'b0;
      check("wfirst BVALID", 32'(BVALID), 1);
      check("wfirst BRESP", 32'(BRESP), 0);
      @(negedge clk);
      BREADY = 1'b0;
      check("wfirst BVALID drop", 32'(BVALID), 0);
      axi_read(BASE + 32'h04, d, r, lat);
      check("wfirst readback", d, 32'h1234_5678);

      // Read backpressure: RREADY low for 5 cycles after RVALID
      @(negedge clk);
      ARVALID = 1'b1; ARADDR = BASE + 32'h04; RREADY = 1'b0;
      @(negedge clk);
      ARVALID = 1'b0;
      n = 0;
      while (!RVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp RVALID seen", 32'(RVALID), 1);
      held = RDATA;
      check("bp RDATA", held, 32'h1234_5678);
      check("bp AWREADY independent", 32'(AWREADY), 1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp RVALID c%0d", k), 32'(RVALID), 1);
         check($sformatf("bp RDATA c%0d", k), RDATA, 32'h1234_5678);
         check($sformatf("bp ARREADY c%0d", k), 32'(ARREADY), 0);
         @(negedge clk);
      end
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      check("bp RVALID after accept", 32'(RVALID), 0);
      check("bp ARREADY after accept", 32'(ARREADY), 1);

      // Read/write collision on index 3 (observed on the RD_LAT=0 slave)
      axi_write(BASE + 32'h0C, 32'h0000_000A, r, lat);
      check("coll init bresp", 32'(r), 0);
      @(negedge clk);
      check("coll z ARREADY", 32'(z_ARREADY), 1);
      ARVALID = 1'b1; ARADDR = BASE + 32'h0C; RREADY = 1'b0;
      AWVALID = 1'b1; AWADDR = BASE + 32'h0C; WVALID = 1'b1; WDATA = 32'h0000_000B; BREADY = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
      check("coll z RVALID", 32'(z_RVALID), 1);
      check("coll z RDATA old", z_RDATA, 32'h0000_000A);
      check("coll z RRESP", 32'(z_RRESP), 0);
      check("coll z BVALID", 32'(z_BVALID), 1);
      RREADY = 1'b1;
      n = 0;
      while (!RVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("coll late sample RDATA", RDATA, 32'h0000_000B);
      @(negedge clk);
      RREADY = 1'b0; BREADY = 1'b0;
      axi_read(BASE + 32'h0C, d, r, lat);
      check("coll readback", d, 32'h0000_000B);
      check("coll z readback", z_RDATA, 32'h0000_000B);

      // Reset during W_RESP
      @(negedge clk);
      AWVALID = 1'b1; AWADDR = BASE + 32'h10; WVALID = 1'b1; WDATA = 32'h0000_0077; BREADY = 1'b0;
      @(negedge clk);
      AWVALID = 1'b0; WVALID = 1'b0;
      check("midrst BVALID before", 32'(BVALID), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst BVALID", 32'(BVALID), 0);
      check("midrst z BVALID", 32'(z_BVALID), 0);
      check("midrst RDATA", RDATA, 0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst AWREADY", 32'(AWREADY), 1);
      for (int w = 0; w < DEPTH; w++) begin
         axi_read(BASE + 32'(w * 4), d, r, lat);
         check($sformatf("cleared word%0d", w), d, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
